// File: rtl/vga_timing_gen_if.sv
// Raster-scan bundle from the VGA timing generator to the color mapper and DAC.
interface vga_timing_gen_if;
  logic       pixel_en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_tick;

  modport master (
    output pixel_en, DrawX, DrawY, blank, hs, vs, frame_tick
  );

  modport slave (
    input pixel_en, DrawX, DrawY, blank, hs, vs, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate enable, h/v counters, delayed blank/sync, frame tick.
// Counters run on the system clock and advance only on the pixel enable strobe.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  vga_timing_gen_if.master  vif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
  localparam logic [2:0] DIV_LAST   = 3'(CLK_DIV - 1);

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing_gen: raster totals must fit in 10 bits");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..8");
  end
  if (PIPE_DELAY > 4) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE_DELAY must be 0..4");
  end

  logic [2:0] r_div_cnt;
  logic [9:0] r_hc;
  logic [9:0] r_vc;
  logic       w_pixel_en;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_blank_raw;
  logic       w_hs_raw;
  logic       w_vs_raw;

  assign w_pixel_en = (r_div_cnt == DIV_LAST);
  assign w_h_last   = (r_hc == H_LAST);
  assign w_v_last   = (r_vc == V_LAST);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_div_cnt <= '0;
    end else if (w_pixel_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 3'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pixel_en) begin
      if (w_h_last) begin
        r_hc <= '0;
        r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  assign w_blank_raw = (r_hc < H_VIS) && (r_vc < V_VIS);
  assign w_hs_raw    = !((r_hc >= H_SYNC_BEG) && (r_hc < H_SYNC_END));
  assign w_vs_raw    = !((r_vc >= V_SYNC_BEG) && (r_vc < V_SYNC_END));

  // Tap 0 is the raw flag; tap k is the flag k pixel strobes old.
  logic [PIPE_DELAY:0] w_blank_tap;
  logic [PIPE_DELAY:0] w_hs_tap;
  logic [PIPE_DELAY:0] w_vs_tap;

  assign w_blank_tap[0] = w_blank_raw;
  assign w_hs_tap[0]    = w_hs_raw;
  assign w_vs_tap[0]    = w_vs_raw;

  for (genvar k = 1; k <= PIPE_DELAY; k++) begin : g_stage
    logic r_blank;
    logic r_hs;
    logic r_vs;

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_blank <= 1'b0;
        r_hs    <= 1'b1;
        r_vs    <= 1'b1;
      end else if (w_pixel_en) begin
        r_blank <= w_blank_tap[k-1];
        r_hs    <= w_hs_tap[k-1];
        r_vs    <= w_vs_tap[k-1];
      end
    end

    assign w_blank_tap[k] = r_blank;
    assign w_hs_tap[k]    = r_hs;
    assign w_vs_tap[k]    = r_vs;
  end

  assign vif.pixel_en   = w_pixel_en;
  assign vif.DrawX      = r_hc;
  assign vif.DrawY      = r_vc;
  assign vif.blank      = w_blank_tap[PIPE_DELAY];
  assign vif.hs         = w_hs_tap[PIPE_DELAY];
  assign vif.vs         = w_vs_tap[PIPE_DELAY];
  // Marks the last strobe of the visible frame, so game logic gets the whole blanking interval.
  assign vif.frame_tick = Reset_n && w_pixel_en && w_h_last && (r_vc == V_VIS_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: full-size raster for line timing,
// reduced rasters for frame-level, mid-frame reset and CLK_DIV=1 checks.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  always #10 Clk = ~Clk;

  logic rst_a, rst_d, rst_b, rst_c;
  int checks = 0;
  int errors = 0;

  vga_timing_gen_if if_a();
  vga_timing_gen_if if_d();
  vga_timing_gen_if if_b();
  vga_timing_gen_if if_c();

  // Full raster, default divider and delay.
  vga_timing_gen u_a (.Clk(Clk), .Reset_n(rst_a), .vif(if_a));

  // Full raster, no delay.
  vga_timing_gen #(.PIPE_DELAY(0)) u_d (.Clk(Clk), .Reset_n(rst_d), .vif(if_d));

  // 16x12 raster: hs low hc 10..12, vs low vc 8..9, frame = 384 Clk.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(2), .PIPE_DELAY(2)
  ) u_b (.Clk(Clk), .Reset_n(rst_b), .vif(if_b));

  // Same raster at one pixel per Clk and four-pixel delay: frame = 192 Clk.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(1), .PIPE_DELAY(4)
  ) u_c (.Clk(Clk), .Reset_n(rst_c), .vif(if_c));

  typedef struct {
    int   n;
    logic pe;
    int   x;
    int   y;
    logic b;
    logic hs;
    logic vs;
    logic ft;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int idx;
    int a_hs_cnt, a_hs_first, a_hs_last;
    int d_hs_cnt, d_hs_first, d_hs_last;
    int a_bl_cnt, a_bl_first, a_bl_last;
    int wraps, last_wrap, prev_x;
    int ntick, ft_samples, last_tick, nfall;
    logic prev_ft, prev_vs, want_y6, found;
    int pe_low, ntick_c, last_tick_c;
    logic prev_ft_c;

    // n = Clk edges since release: pe = n%2, DrawX = n/2, blank/hs = raw flag two pixels back.
    tbl[0]  = '{0,    1'b0, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,    1'b1, 0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2,    1'b0, 1,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{3,    1'b1, 1,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{4,    1'b0, 2,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1283, 1'b1, 641, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1284, 1'b0, 642, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1315, 1'b1, 657, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1316, 1'b0, 658, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1507, 1'b1, 753, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1508, 1'b0, 754, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1599, 1'b1, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1600, 1'b0, 0,   1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1602, 1'b0, 1,   1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1604, 1'b0, 2,   1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_a = 1'b0; rst_d = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) tick();
    rst_a = 1'b1; rst_d = 1'b1;

    // Full raster: table vectors plus line statistics over two lines.
    idx = 0;
    a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1;
    d_hs_cnt = 0; d_hs_first = -1; d_hs_last = -1;
    a_bl_cnt = 0; a_bl_first = -1; a_bl_last = -1;
    wraps = 0; last_wrap = -1; prev_x = 0;
    for (int n = 0; n <= 3205; n++) begin
      if (n > 0) tick();
      if (idx < NV && tbl[idx].n == n) begin
        chk($sformatf("vec%0d.pixel_en", idx), 32'(if_a.pixel_en), 32'(tbl[idx].pe));
        chk($sformatf("vec%0d.DrawX", idx), 32'(if_a.DrawX), 32'(tbl[idx].x));
        chk($sformatf("vec%0d.DrawY", idx), 32'(if_a.DrawY), 32'(tbl[idx].y));
        chk($sformatf("vec%0d.blank", idx), 32'(if_a.blank), 32'(tbl[idx].b));
        chk($sformatf("vec%0d.hs", idx), 32'(if_a.hs), 32'(tbl[idx].hs));
        chk($sformatf("vec%0d.vs", idx), 32'(if_a.vs), 32'(tbl[idx].vs));
        chk($sformatf("vec%0d.frame_tick", idx), 32'(if_a.frame_tick), 32'(tbl[idx].ft));
        idx++;
      end
      if (if_a.DrawY == 10'd0 && if_a.pixel_en) begin
        if (!if_a.hs) begin
          a_hs_cnt++;
          if (a_hs_first < 0) a_hs_first = int'(if_a.DrawX);
          a_hs_last = int'(if_a.DrawX);
        end
        if (if_a.blank) begin
          a_bl_cnt++;
          if (a_bl_first < 0) a_bl_first = int'(if_a.DrawX);
          a_bl_last = int'(if_a.DrawX);
        end
      end
      if (if_d.DrawY == 10'd0 && if_d.pixel_en && !if_d.hs) begin
        d_hs_cnt++;
        if (d_hs_first < 0) d_hs_first = int'(if_d.DrawX);
        d_hs_last = int'(if_d.DrawX);
      end
      if (prev_x == 799 && if_a.DrawX == 10'd0) begin
        wraps++;
        chk("wrap_drawy", 32'(if_a.DrawY), 32'(wraps));
        if (last_wrap >= 0) chk("line_length_clk", 32'(n - last_wrap), 32'd1600);
        last_wrap = n;
      end
      prev_x = int'(if_a.DrawX);
    end
    chk("wrap_count", 32'(wraps), 32'd2);
    chk("a_blank_strobes", 32'(a_bl_cnt), 32'd640);
    chk("a_blank_first_x", 32'(a_bl_first), 32'd2);
    chk("a_blank_last_x", 32'(a_bl_last), 32'd641);
    chk("a_hs_low_strobes", 32'(a_hs_cnt), 32'd96);
    chk("a_hs_first_x", 32'(a_hs_first), 32'd658);
    chk("a_hs_last_x", 32'(a_hs_last), 32'd753);
    chk("d_hs_low_strobes", 32'(d_hs_cnt), 32'd96);
    chk("d_hs_first_x", 32'(d_hs_first), 32'd656);
    chk("d_hs_last_x", 32'(d_hs_last), 32'd751);

    // Reduced raster: vsync window and frame tick over three frames.
    rst_b = 1'b1;
    ntick = 0; ft_samples = 0; last_tick = -1; nfall = -1;
    prev_ft = 1'b0; prev_vs = 1'b1; want_y6 = 1'b0;
    for (int n = 0; n <= 1200; n++) begin
      if (n > 0) tick();
      if (want_y6) begin
        chk("ft_next_drawy", 32'(if_b.DrawY), 32'd6);
        want_y6 = 1'b0;
      end
      if (if_b.frame_tick) begin
        ft_samples++;
        if (!prev_ft) begin
          if (ntick == 0) chk("ft_first_clk", 32'(n), 32'd191);
          else chk("ft_period_clk", 32'(n - last_tick), 32'd384);
          chk("ft_drawx", 32'(if_b.DrawX), 32'd15);
          chk("ft_drawy", 32'(if_b.DrawY), 32'd5);
          chk("ft_pixel_en", 32'(if_b.pixel_en), 32'd1);
          want_y6 = 1'b1;
          last_tick = n;
          ntick++;
        end
      end
      if (prev_vs && !if_b.vs) begin
        nfall = n;
        chk("vs_fall_drawx", 32'(if_b.DrawX), 32'd2);
        chk("vs_fall_drawy", 32'(if_b.DrawY), 32'd8);
      end
      if (!prev_vs && if_b.vs) begin
        chk("vs_low_clk", 32'(n - nfall), 32'd64);
        chk("vs_rise_drawx", 32'(if_b.DrawX), 32'd2);
        chk("vs_rise_drawy", 32'(if_b.DrawY), 32'd10);
      end
      prev_ft = if_b.frame_tick;
      prev_vs = if_b.vs;
    end
    chk("ft_count", 32'(ntick), 32'd3);
    chk("ft_high_samples", 32'(ft_samples), 32'd3);

    // Mid-frame reset at (5,3), right after the pixel advance.
    found = 1'b0;
    for (int k = 0; k < 1000 && !found; k++) begin
      tick();
      if (if_b.DrawX == 10'd5 && if_b.DrawY == 10'd3 && !if_b.pixel_en) found = 1'b1;
    end
    chk("mid_reset_position_found", 32'(found), 32'd1);
    chk("pre_reset_blank", 32'(if_b.blank), 32'd1);
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk("mr_drawx", 32'(if_b.DrawX), 32'd0);
    chk("mr_drawy", 32'(if_b.DrawY), 32'd0);
    chk("mr_blank", 32'(if_b.blank), 32'd0);
    chk("mr_hs", 32'(if_b.hs), 32'd1);
    chk("mr_vs", 32'(if_b.vs), 32'd1);
    chk("mr_frame_tick", 32'(if_b.frame_tick), 32'd0);
    chk("mr_pixel_en", 32'(if_b.pixel_en), 32'd0);
    repeat (3) tick();
    chk("mr_x1_drawx", 32'(if_b.DrawX), 32'd1);
    chk("mr_x1_blank", 32'(if_b.blank), 32'd0);
    tick();
    chk("mr_x2_drawx", 32'(if_b.DrawX), 32'd2);
    chk("mr_x2_blank", 32'(if_b.blank), 32'd1);

    // CLK_DIV=1, PIPE_DELAY=4.
    rst_c = 1'b1;
    pe_low = 0; ntick_c = 0; last_tick_c = -1; prev_ft_c = 1'b0;
    for (int n = 0; n <= 400; n++) begin
      if (n > 0) tick();
      if (!if_c.pixel_en) pe_low++;
      if (n == 3) begin
        chk("c_x3_drawx", 32'(if_c.DrawX), 32'd3);
        chk("c_x3_blank", 32'(if_c.blank), 32'd0);
      end
      if (n == 4) begin
        chk("c_x4_drawx", 32'(if_c.DrawX), 32'd4);
        chk("c_x4_blank", 32'(if_c.blank), 32'd1);
      end
      if (if_c.frame_tick && !prev_ft_c) begin
        if (ntick_c == 0) chk("c_ft_first_clk", 32'(n), 32'd95);
        else chk("c_ft_period_clk", 32'(n - last_tick_c), 32'd192);
        last_tick_c = n;
        ntick_c++;
      end
      prev_ft_c = if_c.frame_tick;
    end
    chk("c_pixel_en_low_cycles", 32'(pe_low), 32'd0);
    chk("c_ft_count", 32'(ntick_c), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
